// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage: PC register, next-PC select, IF/ID register
module if_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] IM_LO     = 32'h0000_3000,
  parameter logic [31:0] IM_HI     = 32'h0000_6FFC,
  parameter logic [4:0]  ERR_NONE  = 5'd31,
  parameter logic [4:0]  EXC_ADEL  = 5'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        branch,
  input  logic        jump,
  input  logic [31:0] branch_addr32,
  input  logic [31:0] jump_addr32,
  input  logic        BranchTypeInstr_ID,
  input  logic        IntReq,
  input  logic        eret,
  input  logic [31:0] EPC,
  output logic [31:0] IM_Addr,
  input  logic [31:0] IM_RData,
  output logic [31:0] PC_out,
  output logic [31:0] Instr_IF_to_ID,
  output logic [31:0] PC_IF_to_ID,
  output logic [31:0] PC_4_IF_to_ID,
  output logic        BD_IF_to_ID,
  output logic [4:0]  ErrStat_IF_to_ID,
  output logic        Err_IF_to_ID
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;
  logic [31:0] fetch_instr;
  logic [31:0] next_pc;

  assign IM_Addr  = pc;
  assign PC_out   = pc;
  assign pc_plus4 = pc + 32'd4;

  // Bad fetches become a nop so nothing downstream acts on garbage before the exception retires.
  assign fetch_err   = (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
  assign fetch_instr = fetch_err ? 32'h0000_0000 : IM_RData;

  always_comb begin
    next_pc = pc_plus4;
    if (jump)        next_pc = jump_addr32;
    else if (branch) next_pc = branch_addr32;
  end

  always_ff @(posedge clk) begin
    if (reset || IntReq || (eret && !Stall)) begin
      if (reset)       pc <= PC_RESET;
      else if (IntReq) pc <= EXC_ENTRY;
      else             pc <= EPC;
      Instr_IF_to_ID   <= 32'h0000_0000;
      PC_IF_to_ID      <= PC_RESET;
      PC_4_IF_to_ID    <= PC_RESET + 32'd4;
      BD_IF_to_ID      <= 1'b0;
      ErrStat_IF_to_ID <= ERR_NONE;
      Err_IF_to_ID     <= 1'b0;
    end else if (!Stall) begin
      pc               <= next_pc;
      Instr_IF_to_ID   <= fetch_instr;
      PC_IF_to_ID      <= pc;
      PC_4_IF_to_ID    <= pc_plus4;
      BD_IF_to_ID      <= BranchTypeInstr_ID;
      ErrStat_IF_to_ID <= fetch_err ? EXC_ADEL : ERR_NONE;
      Err_IF_to_ID     <= fetch_err;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage against a reference fetch model
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Stall = 1'b0, branch = 1'b0, jump = 1'b0;
  logic [31:0] branch_addr32 = '0, jump_addr32 = '0, EPC = '0;
  logic        BranchTypeInstr_ID = 1'b0, IntReq = 1'b0, eret = 1'b0;
  logic [31:0] IM_Addr, IM_RData, PC_out;
  logic [31:0] Instr_IF_to_ID, PC_IF_to_ID, PC_4_IF_to_ID;
  logic        BD_IF_to_ID, Err_IF_to_ID;
  logic [4:0]  ErrStat_IF_to_ID;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ifpc;
    logic [31:0] ifpc4;
    logic        bd;
    logic [4:0]  es;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h3C01_1234 ^ (a << 3);
  endfunction

  assign IM_RData = mem_word(IM_Addr);

  if_stage dut (
    .clk(clk), .reset(reset), .Stall(Stall), .branch(branch), .jump(jump),
    .branch_addr32(branch_addr32), .jump_addr32(jump_addr32),
    .BranchTypeInstr_ID(BranchTypeInstr_ID), .IntReq(IntReq), .eret(eret), .EPC(EPC),
    .IM_Addr(IM_Addr), .IM_RData(IM_RData), .PC_out(PC_out),
    .Instr_IF_to_ID(Instr_IF_to_ID), .PC_IF_to_ID(PC_IF_to_ID), .PC_4_IF_to_ID(PC_4_IF_to_ID),
    .BD_IF_to_ID(BD_IF_to_ID), .ErrStat_IF_to_ID(ErrStat_IF_to_ID), .Err_IF_to_ID(Err_IF_to_ID)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  function automatic exp_t bubble(input logic [31:0] new_pc);
    exp_t e;
    e.pc = new_pc; e.instr = 32'h0; e.ifpc = 32'h3000; e.ifpc4 = 32'h3004;
    e.bd = 1'b0; e.es = 5'd31; e.err = 1'b0;
    return e;
  endfunction

  // Reference: one pipeline step expressed directly from the priority list.
  task automatic step(input bit r, input bit st, input bit br, input bit jp,
                      input logic [31:0] ba, input logic [31:0] ja, input bit bt,
                      input bit ir, input bit er, input logic [31:0] epc);
    bit bad;
    @(negedge clk);
    reset = r; Stall = st; branch = br; jump = jp; branch_addr32 = ba; jump_addr32 = ja;
    BranchTypeInstr_ID = bt; IntReq = ir; eret = er; EPC = epc;
    if (r)                m = bubble(32'h3000);
    else if (ir)          m = bubble(32'h4180);
    else if (er && !st)   m = bubble(epc);
    else if (!st) begin
      bad = (m.pc % 4 != 0) || (m.pc < 32'h3000) || (m.pc > 32'h6FFC);
      m.instr = bad ? 32'h0 : mem_word(m.pc);
      m.ifpc  = m.pc;
      m.ifpc4 = m.pc + 32'd4;
      m.bd    = bt;
      m.es    = bad ? 5'd4 : 5'd31;
      m.err   = bad;
      m.pc    = jp ? ja : (br ? ba : m.pc + 32'd4);
    end
    exp_q.push_back(m);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("im_addr", IM_Addr, e.pc);
        check("pc_out", PC_out, e.pc);
        check("instr", Instr_IF_to_ID, e.instr);
        check("if_pc", PC_IF_to_ID, e.ifpc);
        check("if_pc4", PC_4_IF_to_ID, e.ifpc4);
        check("bd", {31'b0, BD_IF_to_ID}, {31'b0, e.bd});
        check("errstat", {27'b0, ErrStat_IF_to_ID}, {27'b0, e.es});
        check("err", {31'b0, Err_IF_to_ID}, {31'b0, e.err});
      end
    end
  end

  function automatic logic [31:0] rand_target();
    int k;
    k = $urandom_range(0, 9);
    if (k < 8)       return 32'h3000 + (32'($urandom_range(0, 4095)) << 2);
    else if (k == 8) return 32'h3000 + 32'($urandom_range(0, 16383));
    else             return $urandom;
  endfunction

  initial begin
    m = bubble(32'h3000);
    repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) step(0, 1, 0, 1, 0, 32'h3100, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 32'h3100, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 32'h3010, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 32'h3040, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 32'h3002, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 32'h7000, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 32'h3020, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3024);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 32'h6FF8, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 32'h3080, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 32'h3080, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h5000);
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
           rand_target(), rand_target(), $urandom_range(0, 2) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, rand_target());
    end
    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
